vertex_loader: RTL
==================

// Module: vertex_loader
// PURPOSE
//   Loads one triangle (3 vertices) from a byte-wide host pin interface into
//   staging registers, and holds a completed set as "ready". It drives the
//   rasterizer's v*_x / v*_y inputs from an "active" register set. The active set
//   changes only on a frame-commit pulse from VGA timing, so the triangle never
//   tears mid-frame. Sits directly upstream of the raster core.
// PARAMETERS
//   X_W          7   vertex x width (128-column grid)
//   Y_W          6   vertex y width (64-row grid)
//   SYNC_STAGES  2   flops in the strobe/clear pin synchronizers (>=2)
// PORTS
//   clk          in   1    system (pixel) clock
//   rst_n        in   1    asynchronous active-low reset
//   data_in      in   8    host byte; stable while strobe high
//   strobe       in   1    async host write strobe; byte taken on rising edge
//   seq_clr      in   1    async; level high aborts partial set, ptr->0
//   frame_commit in   1    1-cycle pulse, start of vertical blank (sync domain)
//   v0_x,v1_x,v2_x out X_W active vertex x
//   v0_y,v1_y,v2_y out Y_W active vertex y
//   vtx_ready    out  1    completed set waiting for commit
//   load_ptr     out  3    index of next expected byte
// BEHAVIOUR
//   Reset: all staging, ready and active regs = 0; vtx_ready=0; load_ptr=0.
//   strobe/seq_clr pass SYNC_STAGES flops, then a rising-edge detect on strobe
//     -> wr_pulse. Host holds data_in stable >= SYNC_STAGES+2 clk after strobe rise.
//   Byte order (load_ptr): 0 v0_x, 1 v0_y, 2 v1_x, 3 v1_y, 4 v2_x, 5 v2_y.
//     x takes data_in[X_W-1:0]; y takes data_in[Y_W-1:0]; upper bits ignored.
//   On wr_pulse: staging[load_ptr] <= data_in; load_ptr++.
//   On the last byte: ptr wraps to 0. In the same cycle, staging plus the new byte
//     are copied to ready, and complete=1 for one cycle.
//   vtx_ready_next = complete | (vtx_ready & ~frame_commit).
//   On frame_commit with vtx_ready=1: active <= ready (visible next cycle).
//   On frame_commit with vtx_ready=0: no change.
//   Commit + complete in the same cycle: active takes the OLD ready only if
//     vtx_ready was 1. Ready then takes the new set; vtx_ready stays/becomes 1.
//   Second completion before a commit: ready is overwritten (latest wins).
//   Synced seq_clr high: load_ptr=0, wr_pulse ignored. Ready, active and
//     vtx_ready are untouched. seq_clr wins over a same-cycle wr_pulse.
//   Host pulses faster than the sync latency: behaviour is undefined.
//     Minimum strobe low/high time is SYNC_STAGES+2 clk.
//   rst_n low at any time, incl. mid-set: async clear to reset values.
// CONFIGURATION
//   VTX_COLOR_EN defined: the sequence has 7 bytes. Byte 6 = colour, data_in[5:0]
//     as RRGGBB. It is staged, ready and active like the vertices. Extra port:
//     tri_color out 6. The last byte is index 6.
//   VTX_COLOR_EN undefined: 6-byte sequence; no tri_color port or registers.
// STRUCTURE
//   Shared package raster_pkg:
//     - X_W and Y_W defaults
//     - SEQ_LEN (6, or 7 with VTX_COLOR_EN)
//     - byte-index localparams IDX_V0X..IDX_V2Y, IDX_COLOR
//   These are shared with the raster core and the VGA timing block.
//   Sub-module sync_edge (SYNC_STAGES-flop synchronizer plus rising-edge
//     detect) is instantiated for strobe. Only its level output is used for seq_clr.
// TESTING
//   Reset, then send 10,5,60,40,110,20; no commit.
//     -> vtx_ready=1, outputs still 0, load_ptr=0.
//   Pulse frame_commit after the above -> next cycle v0=(10,5) v1=(60,40)
//     v2=(110,20); vtx_ready=0.
//   Send 3 bytes, assert seq_clr, then send 1,2,3,4,5,6 and commit
//     -> v0=(1,2) v1=(3,4) v2=(5,6).
//   Data 0xFF at every index -> x=127, y=63 (truncation).
//   frame_commit in the same cycle as the 6th byte's wr_pulse, vtx_ready=0
//     -> active unchanged, vtx_ready=1. A later commit loads the new set.
//   Assert rst_n low after 4 bytes -> all outputs 0, load_ptr=0 immediately.
//     A fresh 6-byte load then commits correctly.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster constants: default vertex widths, host byte sequence length and byte indices.
// VTX_COLOR_EN adds a seventh byte (the triangle colour) to the sequence.
package raster_pkg;
  localparam int unsigned DEF_X_W = 7;
  localparam int unsigned DEF_Y_W = 6;
  localparam int unsigned COLOR_W = 6;
  localparam int unsigned PTR_W   = 3;

`ifdef VTX_COLOR_EN
  localparam int unsigned SEQ_LEN = 7;
`else
  localparam int unsigned SEQ_LEN = 6;
`endif

  localparam int unsigned IDX_V0X   = 0;
  localparam int unsigned IDX_V0Y   = 1;
  localparam int unsigned IDX_V1X   = 2;
  localparam int unsigned IDX_V1Y   = 3;
  localparam int unsigned IDX_V2X   = 4;
  localparam int unsigned IDX_V2Y   = 5;
  localparam int unsigned IDX_COLOR = 6;
endpackage

// File: rtl/vertex_loader_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with a rising-edge detect on the synced level.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise_c
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the pin through the chain; remember last synced level for edge detect.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = level & ~prev_q;
endmodule

// File: rtl/vertex_loader.sv
// Triangle vertex loader: host bytes -> staging -> ready -> active (swapped only on frame commit).
// VTX_COLOR_EN adds a 6-bit RRGGBB colour byte and the tri_color output.
module vertex_loader
  import raster_pkg::*;
#(
  parameter int unsigned X_W         = DEF_X_W,
  parameter int unsigned Y_W         = DEF_Y_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             strobe,
  input  logic             seq_clr,
  input  logic             frame_commit,
  output logic [X_W-1:0]   v0_x,
  output logic [X_W-1:0]   v1_x,
  output logic [X_W-1:0]   v2_x,
  output logic [Y_W-1:0]   v0_y,
  output logic [Y_W-1:0]   v1_y,
  output logic [Y_W-1:0]   v2_y,
  output logic             vtx_ready,
  output logic [PTR_W-1:0] load_ptr
`ifdef VTX_COLOR_EN
  ,
  output logic [COLOR_W-1:0] tri_color
`endif
);
  typedef struct packed {
    logic [X_W-1:0] v0_x;
    logic [Y_W-1:0] v0_y;
    logic [X_W-1:0] v1_x;
    logic [Y_W-1:0] v1_y;
    logic [X_W-1:0] v2_x;
    logic [Y_W-1:0] v2_y;
`ifdef VTX_COLOR_EN
    logic [COLOR_W-1:0] color;
`endif
  } vset_t;

  vset_t            stage_q, stage_d;
  vset_t            ready_q, ready_d;
  vset_t            active_q, active_d;
  logic             vtx_ready_q, vtx_ready_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             complete_c;
  logic             wr_pulse;
  logic             clr_lvl;
  logic             unused_strobe_lvl;
  logic             unused_clr_rise;
  logic             unused_data_bits;

  sync_edge #(.STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (strobe),
    .level    (unused_strobe_lvl),
    .rise_c   (wr_pulse)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_clr_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (seq_clr),
    .level    (clr_lvl),
    .rise_c   (unused_clr_rise)
  );

  assign unused_data_bits = ^data_in;

  // Byte capture, pointer advance, completion, ready/active hand-off.
  always_comb begin
    stage_d    = stage_q;
    ready_d    = ready_q;
    active_d   = active_q;
    ptr_d      = ptr_q;
    complete_c = 1'b0;

    if (clr_lvl) begin
      ptr_d = '0;
    end else if (wr_pulse) begin
      case (ptr_q)
        PTR_W'(IDX_V0X):   stage_d.v0_x  = data_in[X_W-1:0];
        PTR_W'(IDX_V0Y):   stage_d.v0_y  = data_in[Y_W-1:0];
        PTR_W'(IDX_V1X):   stage_d.v1_x  = data_in[X_W-1:0];
        PTR_W'(IDX_V1Y):   stage_d.v1_y  = data_in[Y_W-1:0];
        PTR_W'(IDX_V2X):   stage_d.v2_x  = data_in[X_W-1:0];
        PTR_W'(IDX_V2Y):   stage_d.v2_y  = data_in[Y_W-1:0];
`ifdef VTX_COLOR_EN
        PTR_W'(IDX_COLOR): stage_d.color = data_in[COLOR_W-1:0];
`endif
        default: ;
      endcase
      if (ptr_q == PTR_W'(SEQ_LEN - 1)) begin
        ptr_d      = '0;
        complete_c = 1'b1;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end

    // stage_d already includes the final byte, so the whole set moves at once.
    if (complete_c) ready_d = stage_d;
    // Active takes the previously completed set; a same-cycle completion waits for the next commit.
    if (frame_commit && vtx_ready_q) active_d = ready_q;
    vtx_ready_d = complete_c | (vtx_ready_q & ~frame_commit);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      ready_q     <= '0;
      active_q    <= '0;
      vtx_ready_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      stage_q     <= stage_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      vtx_ready_q <= vtx_ready_d;
      ptr_q       <= ptr_d;
    end
  end

  assign v0_x      = active_q.v0_x;
  assign v0_y      = active_q.v0_y;
  assign v1_x      = active_q.v1_x;
  assign v1_y      = active_q.v1_y;
  assign v2_x      = active_q.v2_x;
  assign v2_y      = active_q.v2_y;
  assign vtx_ready = vtx_ready_q;
  assign load_ptr  = ptr_q;
`ifdef VTX_COLOR_EN
  assign tri_color = active_q.color;
`endif
endmodule
